// File: rtl/async_pkg.sv
// Shared types and constants for the asynchronous receive bridge family.
// Holds the receive FSM state encoding and the occupancy-counter width helper.
package async_pkg;

  typedef enum logic [0:0] {
    RX_IDLE = 1'b0,
    RX_HOLD = 1'b1
  } rx_state_e;

  // Occupancy counter must represent 0..DEPTH inclusive, hence DEPTH+1 values.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int DEFAULT_DEPTH   = 4;
  localparam int DEFAULT_COUNT_W = $clog2(DEFAULT_DEPTH + 1);

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for a single-bit signal entering the clk domain.
// Clears to 0 on asynchronous active-high reset.
module sync_chain
  import async_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  // Shift the raw input one stage deeper each clock.
  always_comb begin
    chain_d = {chain_q[STAGES-2:0], d};
  end

  // Synchroniser flops; oldest sample sits in the MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q <= {STAGES{1'b0}};
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/async_rx_bridge.sv
// Terminates a 4-phase bundled-data channel from the async LUT pipeline and
// presents the received words as a synchronous valid/ready stream through a
// small circular FIFO. ack is returned in return-to-zero order.
// Optional feature macro: ASYNC_RX_ERR_EN enables the bundling-violation
// detector driving err; without it err is tied low.
module async_rx_bridge
  import async_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req,
  input  logic [WIDTH-1:0]           data,
  output logic                       ack,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       err
);

  localparam int CNT_W = count_width(DEPTH);
  localparam int PTR_W = $clog2(DEPTH);

  logic             req_s;
  logic             full_s;
  logic             push_s;
  logic             pop_s;

  rx_state_e        state_q,     state_d;
  logic             ack_q,       ack_d;
  logic [PTR_W-1:0] wr_ptr_q,    wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,    rd_ptr_d;
  logic [CNT_W-1:0] count_q,     count_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk (clk),
    .rst (rst),
    .d   (req),
    .q   (req_s)
  );

  // Handshake qualifiers; full uses the current count so a same-cycle pop never frees a slot.
  always_comb begin
    full_s = (count_q == CNT_W'(DEPTH));
    push_s = (state_q == RX_IDLE) && req_s && !full_s;
    pop_s  = out_valid_q && out_ready;
  end

  // Return-to-zero handshake: one push per req cycle, ack follows synchronised req.
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    case (state_q)
      RX_IDLE: begin
        if (push_s) begin
          state_d = RX_HOLD;
          ack_d   = 1'b1;
        end else begin
          state_d = RX_IDLE;
          ack_d   = 1'b0;
        end
      end
      RX_HOLD: begin
        if (!req_s) begin
          state_d = RX_IDLE;
          ack_d   = 1'b0;
        end else begin
          state_d = RX_HOLD;
          ack_d   = 1'b1;
        end
      end
      default: begin
        state_d = RX_IDLE;
        ack_d   = 1'b0;
      end
    endcase
  end

  // FIFO pointers, occupancy and storage write.
  always_comb begin
    mem_d = mem_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d        = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Registered head view; a word pushed into an otherwise empty FIFO bypasses storage.
  always_comb begin
    out_valid_d = (count_d != CNT_W'(0));
    if (count_d == CNT_W'(0)) begin
      out_data_d = out_data_q;
    end else if (push_s && (wr_ptr_q == rd_ptr_d)) begin
      out_data_d = data;
    end else begin
      out_data_d = mem_q[rd_ptr_d];
    end
  end

  // State, FIFO and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RX_IDLE;
      ack_q       <= 1'b0;
      wr_ptr_q    <= {PTR_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      count_q     <= {CNT_W{1'b0}};
      out_valid_q <= 1'b0;
      out_data_q  <= {WIDTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

`ifdef ASYNC_RX_ERR_EN
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             err_q,    err_d;

  // Remember the pushed word and flag any data movement while req is still held.
  always_comb begin
    if (push_s) begin
      shadow_d = data;
    end else begin
      shadow_d = shadow_q;
    end
    if ((state_q == RX_HOLD) && req_s && (data != shadow_q)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Shadow word and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= {WIDTH{1'b0}};
      err_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      err_q    <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign ack       = ack_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign count     = count_q;

endmodule

// File: tb/tb_async_rx_bridge.sv
// Directed bench for async_rx_bridge (WIDTH=8, DEPTH=4, SYNC_STAGES=2).
module tb_async_rx_bridge;

  logic       clk;
  logic       rst;
  logic       req;
  logic [7:0] data;
  logic       ack;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] count;
  logic       err;

`ifdef ASYNC_RX_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic       track_max;
  int         max_count;

  typedef struct {
    logic [7:0] din;
    logic [2:0] exp_count;
    logic [7:0] exp_head;
  } vec_t;

  vec_t fill_tbl [4];

  async_rx_bridge #(
    .WIDTH       (8),
    .DEPTH       (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data      (data),
    .ack       (ack),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every word handed to the consumer and the peak occupancy.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) got_q.push_back(out_data);
    if (track_max && (int'(count) > max_count)) max_count = int'(count);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Bounded wait for ack to reach lvl; returns edge count (max+1 on timeout).
  task automatic wait_ack(input logic lvl, input int max, output int n);
    n = 0;
    while (n < max) begin
      @(posedge clk);
      n++;
      #1;
      if (ack === lvl) break;
    end
    if (ack !== lvl) n = max + 1;
    #1;
  endtask

  task automatic xfer_up(input logic [7:0] d);
    int n;
    data = d;
    req  = 1'b1;
    wait_ack(1'b1, 8, n);
    check("ack_rise_latency", 32'((n >= 3) && (n <= 4)), 32'd1);
  endtask

  task automatic xfer_down();
    int n;
    req = 1'b0;
    wait_ack(1'b0, 8, n);
    check("ack_fall_latency", 32'((n >= 3) && (n <= 4)), 32'd1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (count == 3'd0) break;
    end
    out_ready = 1'b0;
    #1;
    check("drain_count", 32'(count), 32'd0);
  endtask

  task automatic compare_order(input string name);
    check({name, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check(name, 32'(got_q[i]), 32'(exp_q[i]));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    fill_tbl[0] = '{din: 8'h3C, exp_count: 3'd1, exp_head: 8'h3C};
    fill_tbl[1] = '{din: 8'h5A, exp_count: 3'd2, exp_head: 8'h3C};
    fill_tbl[2] = '{din: 8'h96, exp_count: 3'd3, exp_head: 8'h3C};
    fill_tbl[3] = '{din: 8'hF0, exp_count: 3'd4, exp_head: 8'h3C};

    rst = 1'b1; req = 1'b0; data = 8'h00; out_ready = 1'b0;
    track_max = 1'b0; max_count = 0;
    repeat (3) step();
    check("reset_ack", 32'(ack), 32'd0);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_count", 32'(count), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    rst = 1'b0;
    repeat (2) step();

    // Single transfer.
    xfer_up(8'hA5);
    step();
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_data", 32'(out_data), 32'hA5);
    check("single_count", 32'(count), 32'd1);
    xfer_down();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    step();
    check("single_pop_count", 32'(count), 32'd0);
    check("single_pop_valid", 32'(out_valid), 32'd0);
    exp_q.push_back(8'hA5);
    compare_order("single_order");

    // Fill to capacity from the vector table.
    for (int i = 0; i < 4; i++) begin
      xfer_up(fill_tbl[i].din);
      xfer_down();
      check("fill_count", 32'(count), 32'(fill_tbl[i].exp_count));
      check("fill_head", 32'(out_data), 32'(fill_tbl[i].exp_head));
    end
    data = 8'h77;
    req  = 1'b1;
    repeat (8) step();
    check("full_ack_stall", 32'(ack), 32'd0);
    check("full_count", 32'(count), 32'd4);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("pop_full_count", 32'(count), 32'd3);
    check("pop_full_no_push", 32'(ack), 32'd0);
    #1 out_ready = 1'b0;
    @(posedge clk); #1;
    check("late_push_ack", 32'(ack), 32'd1);
    check("late_push_count", 32'(count), 32'd4);
    #1;
    xfer_down();
    drain();
    exp_q = '{8'h3C, 8'h5A, 8'h96, 8'hF0, 8'h77};
    compare_order("fill_order");

    // Pointer wrap with a consumer that is always ready.
    out_ready = 1'b1;
    max_count = 0;
    track_max = 1'b1;
    for (int i = 0; i < 10; i++) begin
      xfer_up(8'(i));
      xfer_down();
      exp_q.push_back(8'(i));
    end
    repeat (2) step();
    track_max = 1'b0;
    out_ready = 1'b0;
    check("wrap_max_count", 32'(max_count <= 1), 32'd1);
    compare_order("wrap_order");

    // Simultaneous push and pop at count 2.
    xfer_up(8'h21); xfer_down();
    xfer_up(8'h22); xfer_down();
    check("pp_pre_count", 32'(count), 32'd2);
    data = 8'h23;
    req  = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 out_ready = 1'b1;
    @(posedge clk); #1;
    check("pp_ack", 32'(ack), 32'd1);
    check("pp_count", 32'(count), 32'd2);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("pp_head", 32'(out_data), 32'h22);
    xfer_down();
    drain();
    exp_q = '{8'h21, 8'h22, 8'h23};
    compare_order("pp_order");

    // Data moving while ack is held high.
    xfer_up(8'h11);
    data = 8'h12;
    repeat (2) step();
    check("bundle_err", 32'(err), 32'(EXP_ERR));
    xfer_down();
    repeat (3) step();
    check("bundle_err_sticky", 32'(err), 32'(EXP_ERR));

    // Reset while holding a transfer.
    xfer_up(8'h44);
    #1 rst = 1'b1;
    #1;
    check("rst_hold_ack", 32'(ack), 32'd0);
    check("rst_hold_valid", 32'(out_valid), 32'd0);
    check("rst_hold_count", 32'(count), 32'd0);
    check("rst_hold_err", 32'(err), 32'd0);
    req = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    repeat (4) step();
    check("post_rst_valid", 32'(out_valid), 32'd0);
    check("post_rst_count", 32'(count), 32'd0);
    check("post_rst_ack", 32'(ack), 32'd0);
    got_q.delete();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
